// File: rtl/tff_toggle_arbiter.sv
// Round-robin arbiter that sequences toggle requests into a shared T-type
// register, with a parallel load path and a saturating grant counter.
module tff_toggle_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2,
    parameter int CNTW  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] mask,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_data,
    output logic [NREQ-1:0]       gnt,
    output logic                  gnt_valid,
    output logic [IDW-1:0]        gnt_id,
    output logic [WIDTH-1:0]      q,
    output logic [CNTW-1:0]       toggle_cnt,
    output logic                  cnt_sat
);

    localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

    logic [IDW-1:0]   last;
    logic [IDW-1:0]   win;
    logic             win_found;
    logic [WIDTH-1:0] win_mask;
    logic [CNTW-1:0]  cnt_next;
    int unsigned      idx;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        idx       = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(last) + k) % 32'(NREQ);
            if (!win_found && req[IDW'(idx)]) begin
                win_found = 1'b1;
                win       = IDW'(idx);
            end
        end
    end

    // Select the winner's toggle mask using constant slices only.
    always_comb begin
        win_mask = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDW'(i) == win) begin
                win_mask = mask[i*WIDTH +: WIDTH];
            end
        end
    end

    // Saturating increment; holds once all-ones is reached.
    always_comb begin
        cnt_next = toggle_cnt;
        if (!(&toggle_cnt)) begin
            cnt_next = toggle_cnt + 1'b1;
        end
    end

    // State register: load has priority over grants; idle holds q, pointer, counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q          <= '0;
            gnt        <= '0;
            gnt_valid  <= 1'b0;
            gnt_id     <= '0;
            toggle_cnt <= '0;
            cnt_sat    <= 1'b0;
            last       <= LAST_RST;
        end else if (load) begin
            q         <= load_data;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
        end else if (win_found) begin
            q          <= q ^ win_mask;
            gnt        <= NREQ'(1) << win;
            gnt_valid  <= 1'b1;
            gnt_id     <= win;
            last       <= win;
            toggle_cnt <= cnt_next;
            cnt_sat    <= &cnt_next;
        end else begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
        end
    end

endmodule

// File: tb/tb_tff_toggle_arbiter.sv
// Self-checking bench for tff_toggle_arbiter: directed vector table, corner
// sequences (pointer wrap, saturation, async reset) and randomized traffic
// against a behavioural model.
module tb_tff_toggle_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] mask;
    logic        load;
    logic [7:0]  load_data;
    logic [3:0]  gnt;
    logic        gnt_valid;
    logic [1:0]  gnt_id;
    logic [7:0]  q;
    logic [7:0]  toggle_cnt;
    logic        cnt_sat;

    int total_checks;
    int passed_checks;

    tff_toggle_arbiter #(
        .NREQ (4),
        .WIDTH(8),
        .IDW  (2),
        .CNTW (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .mask      (mask),
        .load      (load),
        .load_data (load_data),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .q         (q),
        .toggle_cnt(toggle_cnt),
        .cnt_sat   (cnt_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] mask;
        logic        load;
        logic [7:0]  ld;
        logic [3:0]  e_gnt;
        logic [1:0]  e_id;
        logic [7:0]  e_q;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t vecs[16];

    // Behavioural model state
    int         m_last;
    logic [7:0] m_q;
    int         m_cnt;
    logic [3:0] m_gnt;
    int         m_id;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act !== exp)
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        else
            passed_checks++;
    endtask

    task automatic check_all(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_id,
                             input logic [7:0] e_q, input logic [7:0] e_cnt);
        chk({tag, ".gnt"},        32'(gnt),        32'(e_gnt));
        chk({tag, ".gnt_valid"},  32'(gnt_valid),  32'(|e_gnt));
        chk({tag, ".gnt_id"},     32'(gnt_id),     32'(e_id));
        chk({tag, ".q"},          32'(q),          32'(e_q));
        chk({tag, ".toggle_cnt"}, 32'(toggle_cnt), 32'(e_cnt));
        chk({tag, ".cnt_sat"},    32'(cnt_sat),    32'(e_cnt == 8'hFF));
    endtask

    task automatic apply(input logic [3:0] r, input logic [31:0] mk, input logic ld, input logic [7:0] ldd);
        req       = r;
        mask      = mk;
        load      = ld;
        load_data = ldd;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    task automatic model_reset();
        m_last = 3;
        m_q    = 8'h00;
        m_cnt  = 0;
        m_gnt  = 4'b0000;
        m_id   = 0;
    endtask

    // Winner = first requesting index in the rotated order last+1, last+2, ...
    task automatic model_edge(input logic [3:0] r, input logic [31:0] mk, input logic ld, input logic [7:0] ldd);
        int w;
        w = -1;
        if (ld) begin
            m_q   = ldd;
            m_gnt = 4'b0000;
            m_id  = 0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                int c;
                c = (m_last + 1 + n) % 4;
                if (w < 0 && r[c]) w = c;
            end
            if (w >= 0) begin
                m_gnt  = 4'(1 << w);
                m_id   = w;
                m_q    = m_q ^ mk[w*8 +: 8];
                m_last = w;
                if (m_cnt < 255) m_cnt++;
            end else begin
                m_gnt = 4'b0000;
                m_id  = 0;
            end
        end
    endtask

    initial begin
        logic [3:0]  r;
        logic [31:0] mk;
        logic        ld;
        logic [7:0]  ldd;
        int          exp_cnt;

        total_checks  = 0;
        passed_checks = 0;
        reset     = 1'b1;
        req       = '0;
        mask      = '0;
        load      = 1'b0;
        load_data = '0;

        vecs[0]  = '{4'b1111, 32'h01010101, 1'b0, 8'h00, 4'b0001, 2'd0, 8'h01, 8'd1};
        vecs[1]  = '{4'b1111, 32'h01010101, 1'b0, 8'h00, 4'b0010, 2'd1, 8'h00, 8'd2};
        vecs[2]  = '{4'b1111, 32'h01010101, 1'b0, 8'h00, 4'b0100, 2'd2, 8'h01, 8'd3};
        vecs[3]  = '{4'b1111, 32'h01010101, 1'b0, 8'h00, 4'b1000, 2'd3, 8'h00, 8'd4};
        vecs[4]  = '{4'b1111, 32'h01010101, 1'b0, 8'h00, 4'b0001, 2'd0, 8'h01, 8'd5};
        vecs[5]  = '{4'b0010, 32'h01010101, 1'b1, 8'hA5, 4'b0000, 2'd0, 8'hA5, 8'd5};
        vecs[6]  = '{4'b0010, 32'h0101FF01, 1'b0, 8'h00, 4'b0010, 2'd1, 8'h5A, 8'd6};
        vecs[7]  = '{4'b0000, 32'h01010101, 1'b1, 8'h00, 4'b0000, 2'd0, 8'h00, 8'd6};
        vecs[8]  = '{4'b0100, 32'h010F0101, 1'b0, 8'h00, 4'b0100, 2'd2, 8'h0F, 8'd7};
        vecs[9]  = '{4'b0100, 32'h010F0101, 1'b0, 8'h00, 4'b0100, 2'd2, 8'h00, 8'd8};
        vecs[10] = '{4'b0100, 32'h010F0101, 1'b0, 8'h00, 4'b0100, 2'd2, 8'h0F, 8'd9};
        vecs[11] = '{4'b1000, 32'h01010101, 1'b0, 8'h00, 4'b1000, 2'd3, 8'h0E, 8'd10};
        vecs[12] = '{4'b1001, 32'h01010101, 1'b0, 8'h00, 4'b0001, 2'd0, 8'h0F, 8'd11};
        vecs[13] = '{4'b1001, 32'h01010101, 1'b0, 8'h00, 4'b1000, 2'd3, 8'h0E, 8'd12};
        vecs[14] = '{4'b0001, 32'h00000000, 1'b0, 8'h00, 4'b0001, 2'd0, 8'h0E, 8'd13};
        vecs[15] = '{4'b0000, 32'h01010101, 1'b0, 8'h00, 4'b0000, 2'd0, 8'h0E, 8'd13};

        // Reset state
        do_reset();
        #1;
        check_all("reset", 4'b0000, 2'd0, 8'h00, 8'd0);

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            apply(vecs[i].req, vecs[i].mask, vecs[i].load, vecs[i].ld);
            check_all($sformatf("vec%0d", i), vecs[i].e_gnt, vecs[i].e_id, vecs[i].e_q, vecs[i].e_cnt);
        end

        // Counter saturation: 260 consecutive grants with zero mask
        do_reset();
        for (int n = 1; n <= 260; n++) begin
            apply(4'b0001, 32'h0, 1'b0, 8'h00);
            exp_cnt = (n < 255) ? n : 255;
            chk($sformatf("sat%0d.cnt", n), 32'(toggle_cnt), 32'(exp_cnt));
            chk($sformatf("sat%0d.sat", n), 32'(cnt_sat), 32'(n >= 255));
        end
        chk("sat.q_hold", 32'(q), 32'h0);

        // Async reset mid-cycle during active grants
        do_reset();
        apply(4'b0000, 32'h0, 1'b1, 8'h3C);
        apply(4'b1111, 32'h0, 1'b0, 8'h00);
        check_all("pre_rst", 4'b0001, 2'd0, 8'h3C, 8'd1);
        #2;
        reset = 1'b0;
        #1;
        check_all("async_rst", 4'b0000, 2'd0, 8'h00, 8'd0);
        #2;
        req   = 4'b1000;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_rst0", 4'b1000, 2'd3, 8'h00, 8'd1);
        apply(4'b1111, 32'h0, 1'b0, 8'h00);
        check_all("post_rst1", 4'b0001, 2'd0, 8'h00, 8'd2);
        // Pointer was at 0; reset must put it back so requester 0 wins again
        do_reset();
        apply(4'b0011, 32'h0, 1'b0, 8'h00);
        check_all("ptr_rst", 4'b0001, 2'd0, 8'h00, 8'd1);

        // Randomized traffic against the behavioural model
        do_reset();
        model_reset();
        for (int i = 0; i < 400; i++) begin
            r   = 4'($urandom);
            if ($urandom_range(0, 3) == 0) r = 4'b1111;
            mk  = $urandom;
            ld  = ($urandom_range(0, 7) == 0);
            ldd = 8'($urandom);
            apply(r, mk, ld, ldd);
            model_edge(r, mk, ld, ldd);
            check_all($sformatf("rnd%0d", i), m_gnt, 2'(m_id), m_q, 8'(m_cnt));
        end

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/tff_toggle_arbiter.md
Name: tff_toggle_arbiter

Overview:
- Shared T-type state register (WIDTH bits) whose bits are toggled on behalf of NREQ requesters.
- A round-robin arbiter grants one requester per cycle. The granted requester's toggle mask is XORed into the register.
- A parallel load path configures or overrides the register contents.
- Sits above the D-to-T flip-flop cells as their sequencer/arbiter. Also keeps a saturating count of applied grants.

Parameters:
- NREQ, 4, number of requesters (2..16)
- WIDTH, 8, width of shared toggle register
- IDW, 2, width of gnt_id; must equal clog2(NREQ)
- CNTW, 8, width of grant counter

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- req  input  NREQ  per-requester toggle request, level
- mask  input  NREQ*WIDTH  per-requester toggle mask; requester i uses bits [i*WIDTH +: WIDTH]
- load  input  1  synchronous parallel load of q
- load_data  input  WIDTH  value loaded into q
- gnt  output  NREQ  one-hot grant pulse, registered
- gnt_valid  output  1  high when any gnt bit is high
- gnt_id  output  IDW  index of granted requester; 0 when gnt_valid low
- q  output  WIDTH  shared toggle register state
- toggle_cnt  output  CNTW  number of grants issued since reset
- cnt_sat  output  1  high while toggle_cnt equals all-ones

Behaviour:
- Reset (reset=0, asynchronous):
  - q=0, gnt=0, gnt_valid=0, gnt_id=0, toggle_cnt=0, cnt_sat=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has top priority first.
- All state updates occur on the rising edge of clk; no combinational path from inputs to outputs.
- Each edge, with reset=1, evaluates in priority order:
  1. load=1:
     - q <= load_data.
     - gnt <= 0, gnt_valid <= 0, gnt_id <= 0.
     - Pointer and counter unchanged.
     - Pending requests are not consumed.
  2. load=0 and any req bit high:
     - Winner w = first i with req[i]=1, searching (last+1) mod NREQ upward with wrap-around.
     - gnt <= one-hot(w), gnt_valid <= 1, gnt_id <= w.
     - q <= q XOR mask[w].
     - last <= w.
     - toggle_cnt <= toggle_cnt+1 unless already all-ones (saturates, never wraps).
  3. No req:
     - gnt <= 0, gnt_valid <= 0, gnt_id <= 0.
     - q, pointer and counter hold.
- Latency:
  - req sampled at edge k gives gnt and the updated q visible after edge k (same edge).
  - A single requester asserting req continuously is granted every cycle.
- Handshake:
  - gnt is a one-cycle pulse per applied toggle.
  - A requester must drop req in the cycle gnt is observed if it wants exactly one toggle.
  - req still high at the next edge counts as a new request. It competes behind the other active requesters (fairness: max wait NREQ-1 grants).
- mask[w]=0: the grant is still issued and counted; q is unchanged.
- cnt_sat is registered alongside toggle_cnt. It is high exactly when toggle_cnt is all-ones.
- Reset mid-operation:
  - Outputs clear immediately on the falling edge of reset, regardless of clk.
  - Pending requests are forgotten and the pointer returns to NREQ-1.

Test Plan:
- Reset then req=4'b1111 held, all masks 8'h01 -> gnt sequence 0001,0010,0100,1000,0001 on successive cycles; q toggles 01,00,01,00,01; toggle_cnt=5.
- load=1, load_data=8'hA5 while req=4'b0010 -> q=A5, gnt=0, counter unchanged. Next cycle, load=0 with mask[1]=8'hFF -> gnt=0010, gnt_id=1, q=5A.
- Only req[2] held high for 3 cycles with mask[2]=8'h0F, q starting at 00 -> gnt=0100 each cycle; q=0F,00,0F.
- Pointer wrap: last grant to requester 3, then req=4'b1001 -> requester 0 granted, then requester 3.
- Counter saturation with CNTW=8: issue 260 grants -> toggle_cnt=255 with cnt_sat=1 from the 255th grant onward, no wrap.
- Assert reset low between edges during active grants with q=3C -> q, gnt, toggle_cnt clear immediately. After release with req=4'b1000, the first grant goes to requester 3 and the pointer restarts from requester 0 priority.
